vga_sincronismo: RTL and testbench
==================================

// Module: vga_sincronismo
// PURPOSE
//  Timing generator for the 640x480@60 Hz VGA path.
//  Divides the system clock down to a pixel-enable tick and runs the horizontal and vertical pixel counters.
//  Drives the monitor's hsync/vsync pins.
//  Feeds linha, coluna and areaAtiva to every ship-drawing block and to the grid/compositor stage.
// PARAMETERS
//  CLK_DIV   2    system clocks per pixel (50 MHz -> 25 MHz); legal range 1..16
//  H_ATIVO   640  visible pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    96   hsync pulse width, in pixels
//  H_BP      48   horizontal back porch; H_TOTAL = 800
//  V_ATIVO   480  visible lines per frame
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    vsync pulse width, in lines
//  V_BP      33   vertical back porch; V_TOTAL = 525
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous reset, active-low
//  pixel_tick   out  1   one-clk pulse, once every CLK_DIV clks
//  coluna       out  10  horizontal counter, 0..H_TOTAL-1
//  linha        out  10  vertical counter, 0..V_TOTAL-1
//  areaAtiva    out  1   1 while coluna<H_ATIVO && linha<V_ATIVO
//  hsync        out  1   active-low horizontal sync
//  vsync        out  1   active-low vertical sync
//  frame_start  out  1   one-clk pulse when counters enter (0,0)
// BEHAVIOUR
//  Reset (async assert, sync release) sets all outputs and state:
//   - coluna=H_TOTAL-1 (799), linha=V_TOTAL-1 (524)
//   - areaAtiva=0, hsync=1, vsync=1, pixel_tick=0, frame_start=0
//   - divider count=0
//  The first pixel_tick after rst_n rises therefore wraps the counters to (0,0) with areaAtiva=1.
//  Divider:
//   - counts 0..CLK_DIV-1 and wraps
//   - pixel_tick is registered; it is 1 in the clk after the count reaches CLK_DIV-1
//   - the first tick comes CLK_DIV clks after reset release
//   - CLK_DIV=1 gives pixel_tick constantly 1 after the first clk
//  Counters change only on clks where the divider wraps, i.e. the same edge that sets pixel_tick.
//   - coluna increments; at H_TOTAL-1 it wraps to 0 and linha increments
//   - linha wraps to 0 at V_TOTAL-1 when coluna also wraps
//   - the simultaneous wrap of both counters makes (0,0) and is the only path to frame_start
//  Decode, registered on the same edge from the next counter values, so all outputs agree in every cycle:
//   - hsync=0 iff H_ATIVO+H_FP <= coluna < H_ATIVO+H_FP+H_SYNC (656..751)
//   - vsync=0 iff V_ATIVO+V_FP <= linha < V_ATIVO+V_FP+V_SYNC (490..491)
//   - areaAtiva per port definition
//   - frame_start=1 for exactly that clk when next is (0,0), else 0
//  Between ticks all outputs hold their values; pixel_tick returns to 0.
//  Widths: counters are 10-bit unsigned; comparisons are unsigned; sums are formed from parameters.
//  Reset mid-frame: outputs return to the reset values immediately. The frame restarts at (0,0) after the next tick. No partial sync pulse is extended.
// STRUCTURE
//  Package vga_pkg holds:
//   - localparams H_TOTAL, V_TOTAL, H_SYNC_INI, H_SYNC_FIM, V_SYNC_INI, V_SYNC_FIM
//   - the 10-bit coordinate width
//  The drawing blocks use the same constants.
//  Sub-module vga_divisor_pixel (clk, rst_n -> pixel_tick), parameterised by CLK_DIV.
//  The counters and decode live in vga_sincronismo.
// TESTING
//  1. Release reset, CLK_DIV=2:
//     - first pixel_tick 2 clks later
//     - coluna=0, linha=0, areaAtiva=1, frame_start=1 for 1 clk
//  2. Run 800 ticks:
//     - hsync low for exactly 96 ticks, starting at coluna=656
//     - areaAtiva=1 for ticks with coluna 0..639
//     - linha increments to 1 when coluna wraps 799->0
//  3. Run one frame (420000 ticks):
//     - vsync low only for linha 490..491
//     - frame_start pulses exactly twice, 420000 ticks apart
//     - areaAtiva count = 307200
//  4. Assert rst_n low at coluna=700, linha=490 (inside hsync and vsync):
//     - same-clk outputs go to hsync=1, vsync=1, coluna=799, linha=524, areaAtiva=0
//     - after release, restart at (0,0)
//  5. CLK_DIV=1:
//     - pixel_tick=1 every clk after reset release
//     - H period 800 clks; frame period 420000 clks
//  6. Assertions, checked every clk:
//     - coluna<800, linha<525
//     - counters never change when pixel_tick is 0
//     - frame_start implies coluna=0 and linha=0

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared 640x480@60 Hz VGA timing constants and coordinate types,
//             used by the sync generator and by every drawing block.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Coordinate width shared by the counters and all drawing blocks
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480@60 Hz geometry (pixels / lines)
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_H_ATIVO = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_V_ATIVO = 480;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BP    = 33;

  // Derived frame constants for the default geometry
  localparam int H_TOTAL    = DEF_H_ATIVO + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL    = DEF_V_ATIVO + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int H_SYNC_INI = DEF_H_ATIVO + DEF_H_FP;
  localparam int H_SYNC_FIM = H_SYNC_INI + DEF_H_SYNC;
  localparam int V_SYNC_INI = DEF_V_ATIVO + DEF_V_FP;
  localparam int V_SYNC_FIM = V_SYNC_INI + DEF_V_SYNC;

  // Registered output bundle of the sync generator
  typedef struct packed {
    coord_t coluna;
    coord_t linha;
    logic   area_ativa;
    logic   hsync;
    logic   vsync;
    logic   frame_start;
  } vga_saida_t;

  // True when ini <= valor < fim (unsigned, half-open interval)
  function automatic logic na_faixa(input coord_t valor,
                                    input int unsigned ini,
                                    input int unsigned fim);
    return (32'(valor) >= ini) && (32'(valor) < fim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_divisor_pixel.sv
`default_nettype none
// ============================================================================
//  Module   : vga_divisor_pixel
//  Purpose  : Divides the system clock into a one-clk pixel tick every
//             CLK_DIV clocks. avanca_o is the combinational strobe for the
//             edge that raises pixel_tick, so the counters can step on that
//             very same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_divisor_pixel #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixel_tick,
  output logic avanca_o
);

  localparam int C_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_ULTIMO = C_CNT_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_clk_div_invalido
      $error("vga_divisor_pixel: CLK_DIV must be within 1..16");
    end
  endgenerate

  logic [C_CNT_W-1:0] cont_q;
  logic [C_CNT_W-1:0] cont_d;
  logic               tick_q;

  // The divider wraps when the count reaches its last value
  assign avanca_o = (cont_q == C_ULTIMO);

  // Next divider count: wrap to zero, otherwise step by one
  always_comb begin
    cont_d = avanca_o ? '0 : cont_q + 1'b1;
  end

  // Count register and registered tick (high the clk after the wrap value)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cont_q <= cont_d;
      tick_q <= avanca_o;
    end
  end

  assign pixel_tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/vga_sincronismo.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sincronismo
//  Purpose  : VGA timing generator. Runs the horizontal/vertical pixel
//             counters on the pixel tick and registers hsync, vsync,
//             areaAtiva and frame_start from the next counter values, so
//             every output changes on the same edge as the counters.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sincronismo
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int H_ATIVO = DEF_H_ATIVO,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_ATIVO = DEF_V_ATIVO,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pixel_tick,
  output logic [COORD_W-1:0] coluna,
  output logic [COORD_W-1:0] linha,
  output logic               areaAtiva,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  // Frame geometry derived from this instance's parameters
  localparam int unsigned C_H_TOTAL    = H_ATIVO + H_FP + H_SYNC + H_BP;
  localparam int unsigned C_V_TOTAL    = V_ATIVO + V_FP + V_SYNC + V_BP;
  localparam int unsigned C_H_ATIVO    = H_ATIVO;
  localparam int unsigned C_V_ATIVO    = V_ATIVO;
  localparam int unsigned C_H_SYNC_INI = H_ATIVO + H_FP;
  localparam int unsigned C_H_SYNC_FIM = C_H_SYNC_INI + H_SYNC;
  localparam int unsigned C_V_SYNC_INI = V_ATIVO + V_FP;
  localparam int unsigned C_V_SYNC_FIM = C_V_SYNC_INI + V_SYNC;
  localparam coord_t      C_H_ULTIMA   = coord_t'(C_H_TOTAL - 1);
  localparam coord_t      C_V_ULTIMA   = coord_t'(C_V_TOTAL - 1);

  // Reset parks the counters on the last pixel so the first tick lands on (0,0)
  localparam vga_saida_t C_SAIDA_RESET = '{
    coluna:      C_H_ULTIMA,
    linha:       C_V_ULTIMA,
    area_ativa:  1'b0,
    hsync:       1'b1,
    vsync:       1'b1,
    frame_start: 1'b0
  };

  generate
    if (C_H_TOTAL > (1 << COORD_W) || C_V_TOTAL > (1 << COORD_W)) begin : g_geometria_invalida
      $error("vga_sincronismo: frame geometry does not fit the coordinate width");
    end
  endgenerate

  logic       avanca;
  coord_t     coluna_d;
  coord_t     linha_d;
  vga_saida_t saida_q;
  vga_saida_t saida_d;

  vga_divisor_pixel #(
    .CLK_DIV (CLK_DIV)
  ) u_divisor (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_tick (pixel_tick),
    .avanca_o   (avanca)
  );

  // Next counter position: step on a divider wrap, carrying into linha at end of line
  always_comb begin
    coluna_d = saida_q.coluna;
    linha_d  = saida_q.linha;
    if (avanca) begin
      if (saida_q.coluna == C_H_ULTIMA) begin
        coluna_d = '0;
        linha_d  = (saida_q.linha == C_V_ULTIMA) ? '0 : saida_q.linha + 1'b1;
      end else begin
        coluna_d = saida_q.coluna + 1'b1;
      end
    end
  end

  // Decode the next position; frame_start only on the edge that enters (0,0)
  always_comb begin
    saida_d.coluna      = coluna_d;
    saida_d.linha       = linha_d;
    saida_d.area_ativa  = (32'(coluna_d) < C_H_ATIVO) && (32'(linha_d) < C_V_ATIVO);
    saida_d.hsync       = !na_faixa(coluna_d, C_H_SYNC_INI, C_H_SYNC_FIM);
    saida_d.vsync       = !na_faixa(linha_d, C_V_SYNC_INI, C_V_SYNC_FIM);
    saida_d.frame_start = avanca && (coluna_d == '0) && (linha_d == '0);
  end

  // Counters and decoded outputs registered together so they always agree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida_q <= C_SAIDA_RESET;
    end else begin
      saida_q <= saida_d;
    end
  end

  assign coluna      = saida_q.coluna;
  assign linha       = saida_q.linha;
  assign areaAtiva   = saida_q.area_ativa;
  assign hsync       = saida_q.hsync;
  assign vsync       = saida_q.vsync;
  assign frame_start = saida_q.frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sincronismo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_vga_sincronismo
//  Purpose  : Self-checking bench. Instance A uses the full 640x480 timing
//             with CLK_DIV=2; instance B uses a shrunken geometry with
//             CLK_DIV=1 so whole frames and the vsync window fit in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sincronismo;

  localparam int A_DIV = 2;
  localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
  localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33;
  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;

  localparam int B_DIV = 1;
  localparam int B_HA = 16, B_HFP = 2, B_HS = 4, B_HBP = 3;
  localparam int B_VA = 12, B_VFP = 2, B_VS = 2, B_VBP = 3;
  localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
  localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
  localparam int B_FRAME = B_HT * B_VT;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] lin;
    logic       area;
    logic       hs;
    logic       vs;
    logic       fs;
  } amostra_t;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  logic       a_tick, a_area, a_hs, a_vs, a_fs;
  logic [9:0] a_col, a_lin;
  logic       b_tick, b_area, b_hs, b_vs, b_fs;
  logic [9:0] b_col, b_lin;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_sincronismo #(
    .CLK_DIV(A_DIV), .H_ATIVO(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ATIVO(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .pixel_tick(a_tick), .coluna(a_col), .linha(a_lin),
    .areaAtiva(a_area), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
  );

  vga_sincronismo #(
    .CLK_DIV(B_DIV), .H_ATIVO(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ATIVO(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .pixel_tick(b_tick), .coluna(b_col), .linha(b_lin),
    .areaAtiva(b_area), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
  );

  // Reference: position of the n-th tick after reset, decoded from scratch
  function automatic amostra_t modelo(longint n, int ha, int hfp, int hs, int hbp,
                                      int va, int vfp, int vs, int vbp);
    amostra_t e;
    int ht, vt, col, lin;
    longint pos;
    ht  = ha + hfp + hs + hbp;
    vt  = va + vfp + vs + vbp;
    pos = n % longint'(ht * vt);
    col = int'(pos % ht);
    lin = int'(pos / ht);
    e.col  = 10'(col);
    e.lin  = 10'(lin);
    e.area = (col < ha) && (lin < va);
    e.hs   = !((col >= ha + hfp) && (col < ha + hfp + hs));
    e.vs   = !((lin >= va + vfp) && (lin < va + vfp + vs));
    e.fs   = (pos == 0);
    return e;
  endfunction

  function automatic amostra_t valor_reset(int ht, int vt);
    amostra_t e;
    e.col  = 10'(ht - 1);
    e.lin  = 10'(vt - 1);
    e.area = 1'b0;
    e.hs   = 1'b1;
    e.vs   = 1'b1;
    e.fs   = 1'b0;
    return e;
  endfunction

  // ---------------- scoreboard for instance A ----------------
  int       a_clks;
  longint   a_ticks;
  bit       a_exp_tick;
  bit       a_prev_ok;
  amostra_t a_q[$];
  amostra_t a_hold;
  amostra_t a_prev;

  always @(posedge clk) begin
    if (!rst_a_n) begin
      a_clks = 0; a_ticks = 0; a_exp_tick = 1'b0; a_prev_ok = 1'b0;
      a_q.delete();
      a_hold = valor_reset(A_HT, A_VT);
    end else begin
      a_clks++;
      a_exp_tick = ((a_clks % A_DIV) == 0);
      if (a_exp_tick) begin
        a_q.push_back(modelo(a_ticks, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP));
        a_ticks++;
      end
    end
  end

  always @(negedge clk) begin
    amostra_t obs, esperado;
    if (rst_a_n) begin
      obs = {a_col, a_lin, a_area, a_hs, a_vs, a_fs};
      vectors++;
      if (a_tick !== a_exp_tick) begin
        miscompares++;
        $display("FAIL a_pixel_tick: got %b expected %b at %0t", a_tick, a_exp_tick, $time);
      end
      if (a_exp_tick) begin
        if (a_q.size() == 0) begin
          miscompares++;
          $display("FAIL a_scoreboard: got empty queue expected entry at %0t", $time);
        end else begin
          a_hold = a_q.pop_front();
        end
      end
      esperado = a_hold;
      if (!a_exp_tick) esperado.fs = 1'b0;
      vectors++;
      if (obs !== esperado) begin
        miscompares++;
        $display("FAIL a_outputs: got col=%0d lin=%0d area=%b hs=%b vs=%b fs=%b expected col=%0d lin=%0d area=%b hs=%b vs=%b fs=%b at %0t",
                 obs.col, obs.lin, obs.area, obs.hs, obs.vs, obs.fs,
                 esperado.col, esperado.lin, esperado.area, esperado.hs, esperado.vs, esperado.fs, $time);
      end
      vectors++;
      if (a_col >= 10'(A_HT) || a_lin >= 10'(A_VT) || (a_fs && (a_col != 0 || a_lin != 0)) ||
          (a_prev_ok && !a_tick && (a_col !== a_prev.col || a_lin !== a_prev.lin))) begin
        miscompares++;
        $display("FAIL a_invariant: got col=%0d lin=%0d tick=%b fs=%b expected in-range, stable without tick, fs only at (0,0)",
                 a_col, a_lin, a_tick, a_fs);
      end
      a_prev = obs;
      a_prev_ok = 1'b1;
    end
  end

  // ---------------- scoreboard for instance B ----------------
  int       b_clks;
  longint   b_ticks;
  bit       b_exp_tick;
  bit       b_prev_ok;
  amostra_t b_q[$];
  amostra_t b_hold;
  amostra_t b_prev;

  always @(posedge clk) begin
    if (!rst_b_n) begin
      b_clks = 0; b_ticks = 0; b_exp_tick = 1'b0; b_prev_ok = 1'b0;
      b_q.delete();
      b_hold = valor_reset(B_HT, B_VT);
    end else begin
      b_clks++;
      b_exp_tick = ((b_clks % B_DIV) == 0);
      if (b_exp_tick) begin
        b_q.push_back(modelo(b_ticks, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP));
        b_ticks++;
      end
    end
  end

  always @(negedge clk) begin
    amostra_t obs, esperado;
    if (rst_b_n) begin
      obs = {b_col, b_lin, b_area, b_hs, b_vs, b_fs};
      vectors++;
      if (b_tick !== b_exp_tick) begin
        miscompares++;
        $display("FAIL b_pixel_tick: got %b expected %b at %0t", b_tick, b_exp_tick, $time);
      end
      if (b_exp_tick) begin
        if (b_q.size() == 0) begin
          miscompares++;
          $display("FAIL b_scoreboard: got empty queue expected entry at %0t", $time);
        end else begin
          b_hold = b_q.pop_front();
        end
      end
      esperado = b_hold;
      if (!b_exp_tick) esperado.fs = 1'b0;
      vectors++;
      if (obs !== esperado) begin
        miscompares++;
        $display("FAIL b_outputs: got col=%0d lin=%0d area=%b hs=%b vs=%b fs=%b expected col=%0d lin=%0d area=%b hs=%b vs=%b fs=%b at %0t",
                 obs.col, obs.lin, obs.area, obs.hs, obs.vs, obs.fs,
                 esperado.col, esperado.lin, esperado.area, esperado.hs, esperado.vs, esperado.fs, $time);
      end
      vectors++;
      if (b_col >= 10'(B_HT) || b_lin >= 10'(B_VT) || (b_fs && (b_col != 0 || b_lin != 0)) ||
          (b_prev_ok && !b_tick && (b_col !== b_prev.col || b_lin !== b_prev.lin))) begin
        miscompares++;
        $display("FAIL b_invariant: got col=%0d lin=%0d tick=%b fs=%b expected in-range, stable without tick, fs only at (0,0)",
                 b_col, b_lin, b_tick, b_fs);
      end
      b_prev = obs;
      b_prev_ok = 1'b1;
    end
  end

  // Bounded waits for the next pixel tick (sampled on the falling edge)
  task automatic espera_tick_a(output bit ok);
    int n = 0;
    do begin @(negedge clk); n++; end while (a_tick !== 1'b1 && n < 64);
    ok = (a_tick === 1'b1);
  endtask

  task automatic espera_tick_b(output bit ok);
    int n = 0;
    do begin @(negedge clk); n++; end while (b_tick !== 1'b1 && n < 64);
    ok = (b_tick === 1'b1);
  endtask

  task automatic test_reset_a();
    int n;
    rst_a_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({a_col, a_lin, a_area, a_hs, a_vs, a_tick, a_fs} !== {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_a: got col=%0d lin=%0d area=%b hs=%b vs=%b tick=%b fs=%b expected 799 524 0 1 1 0 0",
               a_col, a_lin, a_area, a_hs, a_vs, a_tick, a_fs);
    end
    rst_a_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (a_tick !== 1'b1 && n < 20);
    vectors++;
    if (n !== 2) begin
      miscompares++;
      $display("FAIL first_tick_a: got latency %0d expected 2", n);
    end
    vectors++;
    if ({a_col, a_lin, a_area, a_fs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL first_pixel_a: got col=%0d lin=%0d area=%b fs=%b expected 0 0 1 1", a_col, a_lin, a_area, a_fs);
    end
    @(negedge clk);
    vectors++;
    if ({a_tick, a_fs, a_col} !== {1'b0, 1'b0, 10'd0}) begin
      miscompares++;
      $display("FAIL hold_a: got tick=%b fs=%b col=%0d expected 0 0 0", a_tick, a_fs, a_col);
    end
  endtask

  task automatic test_linha_a();
    int  hs_low = 0, area_cnt = 1, first_hs = -1, last_hs = -1;
    bit  ok, timeout = 1'b0;
    for (int t = 1; t < A_HT; t++) begin
      espera_tick_a(ok);
      if (!ok) timeout = 1'b1;
      if (a_hs === 1'b0) begin
        if (first_hs < 0) first_hs = int'(a_col);
        last_hs = int'(a_col);
        hs_low++;
      end
      if (a_area === 1'b1) area_cnt++;
    end
    espera_tick_a(ok);
    if (!ok) timeout = 1'b1;
    vectors++;
    if (timeout) begin
      miscompares++;
      $display("FAIL line_timeout_a: got missing ticks expected 800 ticks");
    end
    vectors++;
    if (hs_low !== 96 || first_hs !== 656 || last_hs !== 751) begin
      miscompares++;
      $display("FAIL hsync_window_a: got %0d ticks from %0d to %0d expected 96 ticks from 656 to 751", hs_low, first_hs, last_hs);
    end
    vectors++;
    if (area_cnt !== 640) begin
      miscompares++;
      $display("FAIL area_line_a: got %0d expected 640", area_cnt);
    end
    vectors++;
    if ({a_col, a_lin} !== {10'd0, 10'd1}) begin
      miscompares++;
      $display("FAIL line_wrap_a: got col=%0d lin=%0d expected 0 1", a_col, a_lin);
    end
  endtask

  task automatic test_reset_meio_a();
    int n = 0;
    bit ok;
    do begin espera_tick_a(ok); n++; end while (a_col !== 10'd700 && n < 1000);
    vectors++;
    if (a_col !== 10'd700 || a_hs !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_a: got col=%0d hs=%b expected 700 0", a_col, a_hs);
    end
    #1 rst_a_n = 1'b0;
    #1;
    vectors++;
    if ({a_col, a_lin, a_area, a_hs, a_vs, a_tick, a_fs} !== {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset_a: got col=%0d lin=%0d area=%b hs=%b vs=%b tick=%b fs=%b expected 799 524 0 1 1 0 0",
               a_col, a_lin, a_area, a_hs, a_vs, a_tick, a_fs);
    end
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (a_tick !== 1'b1 && n < 20);
    vectors++;
    if (n !== 2 || {a_col, a_lin, a_area, a_fs} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL restart_a: got latency=%0d col=%0d lin=%0d area=%b fs=%b expected 2 0 0 1 1", n, a_col, a_lin, a_area, a_fs);
    end
  endtask

  task automatic test_quadro_b();
    int tick_cnt = 0, area_cnt = 0, vs_low = 0, vs_min = 1023, vs_max = -1;
    int fs_clks[$];
    int hs_fall[$];
    logic prev_hs = 1'b1;
    vectors++;
    if ({b_col, b_lin, b_area, b_hs, b_vs, b_tick, b_fs} !== {10'(B_HT - 1), 10'(B_VT - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_b: got col=%0d lin=%0d area=%b hs=%b vs=%b tick=%b fs=%b expected %0d %0d 0 1 1 0 0",
               b_col, b_lin, b_area, b_hs, b_vs, b_tick, b_fs, B_HT - 1, B_VT - 1);
    end
    rst_b_n = 1'b1;
    for (int c = 1; c <= B_FRAME + 1; c++) begin
      @(negedge clk);
      if (b_tick === 1'b1) tick_cnt++;
      if (b_fs === 1'b1) fs_clks.push_back(c);
      if (c <= B_FRAME) begin
        if (b_area === 1'b1) area_cnt++;
        if (b_vs === 1'b0) begin
          vs_low++;
          if (int'(b_lin) < vs_min) vs_min = int'(b_lin);
          if (int'(b_lin) > vs_max) vs_max = int'(b_lin);
        end
      end
      if (prev_hs === 1'b1 && b_hs === 1'b0) hs_fall.push_back(c);
      prev_hs = b_hs;
    end
    vectors++;
    if (tick_cnt !== B_FRAME + 1) begin
      miscompares++;
      $display("FAIL tick_every_clk_b: got %0d expected %0d", tick_cnt, B_FRAME + 1);
    end
    vectors++;
    if (fs_clks.size() !== 2) begin
      miscompares++;
      $display("FAIL frame_start_count_b: got %0d expected 2", fs_clks.size());
    end else begin
      vectors++;
      if (fs_clks[0] !== 1 || fs_clks[1] - fs_clks[0] !== B_FRAME) begin
        miscompares++;
        $display("FAIL frame_period_b: got first=%0d period=%0d expected 1 %0d", fs_clks[0], fs_clks[1] - fs_clks[0], B_FRAME);
      end
    end
    vectors++;
    if (area_cnt !== B_HA * B_VA) begin
      miscompares++;
      $display("FAIL area_frame_b: got %0d expected %0d", area_cnt, B_HA * B_VA);
    end
    vectors++;
    if (vs_low !== B_VS * B_HT || vs_min !== B_VA + B_VFP || vs_max !== B_VA + B_VFP + B_VS - 1) begin
      miscompares++;
      $display("FAIL vsync_window_b: got %0d ticks lines %0d..%0d expected %0d ticks lines %0d..%0d",
               vs_low, vs_min, vs_max, B_VS * B_HT, B_VA + B_VFP, B_VA + B_VFP + B_VS - 1);
    end
    vectors++;
    if (hs_fall.size() < 2 || hs_fall[1] - hs_fall[0] !== B_HT) begin
      miscompares++;
      $display("FAIL h_period_b: got %0d falls expected period %0d", hs_fall.size(), B_HT);
    end
  endtask

  task automatic test_reset_meio_b();
    int n = 0;
    bit ok;
    do begin espera_tick_b(ok); n++; end
      while (!(b_col === 10'(B_HA + B_HFP + 2) && b_lin === 10'(B_VA + B_VFP)) && n < 1000);
    vectors++;
    if (b_hs !== 1'b0 || b_vs !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_b: got col=%0d lin=%0d hs=%b vs=%b expected inside both sync pulses", b_col, b_lin, b_hs, b_vs);
    end
    #1 rst_b_n = 1'b0;
    #1;
    vectors++;
    if ({b_col, b_lin, b_area, b_hs, b_vs, b_tick, b_fs} !== {10'(B_HT - 1), 10'(B_VT - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset_b: got col=%0d lin=%0d area=%b hs=%b vs=%b tick=%b fs=%b expected %0d %0d 0 1 1 0 0",
               b_col, b_lin, b_area, b_hs, b_vs, b_tick, b_fs, B_HT - 1, B_VT - 1);
    end
    repeat (2) @(negedge clk);
    rst_b_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (b_tick !== 1'b1 && n < 20);
    vectors++;
    if (n !== 1 || {b_col, b_lin, b_area, b_fs, b_hs, b_vs} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL restart_b: got latency=%0d col=%0d lin=%0d area=%b fs=%b expected 1 0 0 1 1", n, b_col, b_lin, b_area, b_fs);
    end
    @(negedge clk);
    vectors++;
    if ({b_tick, b_col, b_fs} !== {1'b1, 10'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL second_tick_b: got tick=%b col=%0d fs=%b expected 1 1 0", b_tick, b_col, b_fs);
    end
  endtask

  initial begin
    test_reset_a();
    test_linha_a();
    test_reset_meio_a();
    test_quadro_b();
    test_reset_meio_b();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
